mem_wb_skid_stage: RTL
======================

Name: mem_wb_skid_stage

Overview:
- Parametrised successor of the MEM→WB pipeline register.
- Carries the writeback bundle (integer/float write enables, destination register, load data, ALU result) from MEM to WB.
- Adds a valid/ready handshake, a 2-entry skid buffer so back-pressure from WB never combinationally reaches MEM, a flush input, a pre-muxed writeback value and a retired-instruction counter.

Parameters:
- XLEN, 32, width of data paths (load data, ALU result, writeback value).
- REG_AW, 5, register-index width.
- CNT_W, 32, width of retire counter.

Ports:
- clk  input  1  clock; all state changes on posedge clk.
- rst  input  1  synchronous active-low reset; sampled on posedge clk.
- flush  input  1  kill all held entries; drop the input offered this cycle.
- in_valid  input  1  MEM offers a bundle.
- in_ready  output  1  stage can accept; in_fire = in_valid & in_ready.
- in_regwrite  input  1  integer register write request.
- in_fregwrite  input  1  float register write request.
- in_rd  input  REG_AW  destination register index.
- in_memtoreg  input  1  1 = write load data, 0 = write ALU result.
- in_mem_data  input  XLEN  load data after halfword/byte handling.
- in_alu_result  input  XLEN  ALU result.
- out_valid  output  1  WB bundle present.
- out_ready  input  1  WB consumes; out_fire = out_valid & out_ready.
- out_regwrite  output  1  gated integer write enable.
- out_fregwrite  output  1  gated float write enable.
- out_rd  output  REG_AW  destination index.
- out_wdata  output  XLEN  selected writeback value.
- retire_cnt  output  CNT_W  count of out_fire events.

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-low.
  - While rst=0 at a posedge, the next state is: state EMPTY; main and skid entries cleared (all fields 0); retire_cnt=0.
  - Outputs after reset: out_valid=0, out_regwrite=0, out_fregwrite=0, out_rd=0, out_wdata=0.
  - in_ready is forced 0 while rst=0, regardless of state.
  - Reset asserted mid-operation discards all held entries with no output.
- Capture:
  - An entry stores regwrite, fregwrite, rd, and wdata = memtoreg ? mem_data : alu_result.
  - The mux is evaluated at capture; memtoreg itself is not stored.
- Output path:
  - Outputs are driven only from the main entry (registered).
  - out_regwrite = out_valid & main.regwrite & (main.rd != 0). Integer x0 is never written.
  - out_fregwrite = out_valid & main.fregwrite. f0 is writable.
- in_ready = rst & (state != FULL). It is a function of registered state only, with no path from out_ready.
- States and transitions (no flush):
  - EMPTY: in_fire → BUSY, main<=in; else stay.
  - BUSY:
    - in_fire & out_fire → BUSY, main<=in.
    - in_fire & !out_fire → FULL, skid<=in.
    - !in_fire & out_fire → EMPTY.
    - neither → stay, hold.
  - FULL (in_ready=0): out_fire → BUSY, main<=skid; else hold both.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustains 1 bundle/cycle while out_ready=1.
- Flush: highest priority after reset.
  - At the posedge with flush=1, the next state is EMPTY and both entries are invalidated.
  - The input offered that cycle is dropped even if in_fire=1.
  - An out_fire in the flush cycle still counts as delivered; WB must honour it.
- Ordering: strict FIFO; the skid entry is always older than any new input.
- retire_cnt:
  - +1 on each out_fire, with wrap-around modulo 2^CNT_W (all-ones +1 → 0).
  - Not affected by flush.
- Outputs hold stable while out_valid=1 & out_ready=0.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, retire_cnt=0. After rst=1, in_ready=1 on the next cycle.
- Streaming: out_ready=1; send 4 bundles with rd=1..4, memtoreg alternating 1/0, mem_data=0xAAAA0000+i, alu_result=0x5555+i → out_wdata 0xAAAA0001, 0x5557, 0xAAAA0003, 0x5559 on consecutive cycles, each 1 cycle after input; retire_cnt=4.
- Back-pressure: hold out_ready=0 and offer 3 bundles → accepts 2 (BUSY then FULL), in_ready=0 from the 3rd. Release out_ready → bundles emerge in order and in_ready returns 1 one cycle after the first out_fire.
- x0 gating: send regwrite=1, rd=0 and fregwrite=1, rd=0 → out_regwrite=0 for the first; out_fregwrite=1 for the second.
- Flush in FULL with in_valid=1 and out_ready=1 → the main bundle is delivered and counted (retire_cnt+1); the skid entry and the new input are dropped; out_valid=0 next cycle.
- Wrap: with CNT_W=4, 17 transfers → retire_cnt=1.

Source files
------------

// File: rtl/mem_wb_skid_stage_if.sv
// MEM -> WB writeback bundle interface.
// master: the MEM/WB environment side; slave: the skid stage itself.
interface mem_wb_skid_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              flush;

    logic              in_valid;
    logic              in_ready;
    logic              in_regwrite;
    logic              in_fregwrite;
    logic [REG_AW-1:0] in_rd;
    logic              in_memtoreg;
    logic [XLEN-1:0]   in_mem_data;
    logic [XLEN-1:0]   in_alu_result;

    logic              out_valid;
    logic              out_ready;
    logic              out_regwrite;
    logic              out_fregwrite;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_wdata;

    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output flush,
        output in_valid, in_regwrite, in_fregwrite, in_rd, in_memtoreg,
        output in_mem_data, in_alu_result,
        input  in_ready,
        input  out_valid, out_regwrite, out_fregwrite, out_rd, out_wdata,
        output out_ready,
        input  retire_cnt
    );

    modport slave (
        input  flush,
        input  in_valid, in_regwrite, in_fregwrite, in_rd, in_memtoreg,
        input  in_mem_data, in_alu_result,
        output in_ready,
        output out_valid, out_regwrite, out_fregwrite, out_rd, out_wdata,
        input  out_ready,
        output retire_cnt
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM -> WB pipeline stage with a 2-entry skid buffer.
// in_ready depends only on registered state, so WB back-pressure never
// reaches MEM combinationally. The writeback mux is resolved at capture.
//
// state | meaning
// ------+---------------------------------------------------------
// EMPTY | no bundle held; outputs idle
// BUSY  | main entry holds the bundle presented to WB
// FULL  | main presented, skid holds the next (older than any new input)
module mem_wb_skid_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_wb_skid_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              regwrite;
        logic              fregwrite;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    entry_t in_entry;
    logic   in_ready;
    logic   in_fire;
    logic   out_valid;
    logic   out_fire;

    assign in_ready  = rst & (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    // Build the captured entry; memtoreg is consumed here and not stored.
    always_comb begin
        in_entry.regwrite  = bus.in_regwrite;
        in_entry.fregwrite = bus.in_fregwrite;
        in_entry.rd        = bus.in_rd;
        in_entry.wdata     = bus.in_memtoreg ? bus.in_mem_data : bus.in_alu_result;
    end

    // Next-state and entry movement; flush empties the stage and drops the input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (bus.flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d = S_BUSY;
                        main_d  = in_entry;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = S_FULL;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d = S_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Retire counter: one per delivered bundle, wraps naturally; flush does not touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State, entries and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_regwrite  = out_valid & main_q.regwrite & (main_q.rd != '0);
    assign bus.out_fregwrite = out_valid & main_q.fregwrite;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_wdata     = main_q.wdata;
    assign bus.retire_cnt    = cnt_q;

endmodule
